// File: rtl/shift_sequencer.sv
// Purpose : multi-cycle barrel shifter that shifts a 32-bit operand by up to STEP_MAX bits per cycle.
// Latency : max(1, ceil(shamt/STEP_MAX)) SHIFT cycles plus one DONE cycle after start is sampled.
// Backpr. : none; start is sampled only in IDLE and dropped while busy, flush aborts to IDLE.
//
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-low reset
//   start  - request strobe, accepted only in IDLE
//   flush  - synchronous abort, wins over start
//   a      - 32-bit operand, latched on accept
//   shamt  - shift amount 0..31, latched on accept
//   dir    - 0 = left, 1 = right, latched on accept
//   shtype - right-shift fill: 0 = logical, 1 = arithmetic (named shtype: "type" is a reserved word)
//   busy   - high in SHIFT and DONE
//   done   - one-cycle pulse in DONE
//   out    - result register, updated only on entry to DONE
//
// Build option: define SHIFT_SEQ_ZERO_BYPASS_EN to send shamt=0 requests
// straight from IDLE to DONE instead of spending one zero-step SHIFT cycle.

module shift_sequencer #(
  parameter int STEP_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        flush,
  input  logic [31:0] a,
  input  logic [4:0]  shamt,
  input  logic        dir,
  input  logic        shtype,
  output logic        busy,
  output logic        done,
  output logic [31:0] out
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [4:0] STEP_LIM = 5'(STEP_MAX);

  logic [1:0]  state;
  logic [31:0] acc;
  logic [4:0]  rem;
  logic        cfg_dir;
  logic        cfg_type;
  logic        sign;

  logic [4:0]  step;
  logic [4:0]  rem_next;
  logic [31:0] fill_mask;
  logic [31:0] acc_shifted;

  // Per-cycle step is the smaller of what is left and the per-cycle limit.
  always_comb begin
    step      = (rem < STEP_LIM) ? rem : STEP_LIM;
    rem_next  = rem - step;
    // Bits vacated at the top by a right shift of 'step'.
    fill_mask = ~(32'hFFFF_FFFF >> step);
    if (cfg_dir) begin
      acc_shifted = acc >> step;
      if (cfg_type && sign) begin
        acc_shifted = acc_shifted | fill_mask;
      end
    end else begin
      acc_shifted = acc << step;
    end
  end

  assign busy = (state == SHIFT) || (state == DONE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      acc      <= '0;
      rem      <= '0;
      cfg_dir  <= 1'b0;
      cfg_type <= 1'b0;
      sign     <= 1'b0;
      out      <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc      <= a;
            rem      <= shamt;
            cfg_dir  <= dir;
            cfg_type <= shtype;
            sign     <= a[31];
`ifdef SHIFT_SEQ_ZERO_BYPASS_EN
            if (shamt == 5'd0) begin
              state <= DONE;
              out   <= a;
            end else begin
              state <= SHIFT;
            end
`else
            state <= SHIFT;
`endif
          end
        end
        SHIFT: begin
          acc <= acc_shifted;
          rem <= rem_next;
          // out takes the final accumulator value on the DONE entry edge.
          if (rem_next == 5'd0) begin
            state <= DONE;
            out   <= acc_shifted;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter STEP_MAX, default 4, SHALL set the maximum bits shifted per SHIFT cycle; legal values 1, 2, 4, 8, 16.
REQ-002 Port clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 Port rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 Port start  input  1  SHALL be the request strobe; sampled only in IDLE.
REQ-005 Port flush  input  1  SHALL be the synchronous abort of any operation in progress.
REQ-006 Port a  input  32  SHALL be the operand, latched when start is accepted.
REQ-007 Port shamt  input  5  SHALL be the shift amount 0..31, latched when start is accepted.
REQ-008 Port dir  input  1  SHALL select direction: 0 = left, 1 = right; latched when start is accepted.
REQ-009 Port type  input  1  SHALL select fill on right shifts: 0 = logical, 1 = arithmetic; latched when start is accepted; ignored for left shifts.
REQ-010 Port busy  output  1  SHALL be high in SHIFT and DONE.
REQ-011 Port done  output  1  SHALL be a single-cycle pulse, high only in DONE.
REQ-012 Port out  output  32  SHALL be the result register.

Function
REQ-013 FSM states SHALL be IDLE, SHIFT and DONE, encoded in 2 bits; the fourth encoding SHALL return to IDLE on the next edge.
REQ-014 IDLE with start=1, flush=0 SHALL latch a into the accumulator, shamt into the remaining count, dir/type into config, and a[31] as the sign fill, then go to SHIFT.
REQ-015 In SHIFT, each cycle SHALL shift the accumulator by step = min(remaining, STEP_MAX) and set remaining = remaining - step.
REQ-016 Fill SHALL be zeros for left and for logical right shifts, and the latched sign bit for arithmetic right shifts.
REQ-017 SHIFT SHALL go to DONE on the cycle remaining reaches 0, otherwise stay in SHIFT.
REQ-018 On entry to DONE, out SHALL load the accumulator; DONE SHALL last exactly one cycle, then return to IDLE.
REQ-019 Latency from the accepting edge to done high SHALL be max(1, ceil(shamt/STEP_MAX)) cycles plus 1.
REQ-020 out SHALL hold its value until the next DONE entry; it is not modified in IDLE or SHIFT.
REQ-021 start while busy=1 SHALL be ignored, with no queuing.
REQ-022 flush=1 in any state SHALL force IDLE on the next edge with no done pulse and out unchanged; flush takes priority over a simultaneous start.
REQ-023 shamt=0 (macro absent) SHALL spend one SHIFT cycle with step 0; out = a.

Reset
REQ-024 rst low SHALL immediately force state=IDLE, out=0, busy=0, done=0, accumulator=0, remaining=0, config=0, independent of clk.
REQ-025 Reset asserted mid-operation SHALL abandon the operation with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Configuration
REQ-026 With macro SHIFT_SEQ_ZERO_BYPASS_EN defined, accepting start with shamt=0 SHALL go directly from IDLE to DONE with out=a, giving done 1 cycle after acceptance.
REQ-027 With SHIFT_SEQ_ZERO_BYPASS_EN undefined, the shamt=0 case SHALL follow REQ-023, giving done 2 cycles after acceptance.

Verification
REQ-028 a=0x80000000, shamt=3, dir=0, type=0 -> out=0x00000000, done 2 cycles after acceptance (STEP_MAX=4).
REQ-029 a=0x80000000, shamt=1, dir=1, type=0 -> out=0x40000000; same with type=1 -> out=0xC0000000.
REQ-030 a=0x80000001, shamt=31, dir=1, type=1, STEP_MAX=4 -> 8 SHIFT cycles, done 9 cycles after acceptance, out=0xFFFFFFFF.
REQ-031 Second start one cycle after acceptance, with shamt=20 -> ignored; first result is unaffected; exactly one done pulse.
REQ-032 flush on the 2nd SHIFT cycle of shamt=16 -> IDLE with no done and out holding its prior value; a new start one cycle later completes correctly.
REQ-033 shamt=0, a=0x12345678 -> out=0x12345678, done at +1 cycle with the macro defined and at +2 cycles without it; rst pulsed mid-SHIFT -> all outputs 0 immediately.
